// File: rtl/shift_serializer_if.sv
// Word handshake and serial-output bundle between an upstream word source and
// shift_serializer; master is the source side, slave is the serializer.
interface shift_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_i;
    logic             data_valid_i;
    logic             ready_o;
    logic             x_o;
    logic             bit_valid_o;
    logic             word_last_o;
    logic             busy_o;

    modport master (
        output data_i, data_valid_i,
        input  ready_o, x_o, bit_valid_o, word_last_o, busy_o
    );

    modport slave (
        input  data_i, data_valid_i,
        output ready_o, x_o, bit_valid_o, word_last_o, busy_o
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and emits
// one bit per clock on x_o, with an optional forced idle gap after each word.
module shift_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    shift_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

    logic last_bit_s;
    logic ready_s;
    logic accept_s;
    logic out_bit_s;
    logic [WIDTH-1:0] shifted_s;

    // Output decode from registered state; reset forces every output low at once.
    always_comb begin
        last_bit_s = (state_q == S_SHIFT) && (bit_cnt_q == '0);
        ready_s    = !reset && ((state_q == S_IDLE) || (last_bit_s && !HAS_GAP));
        accept_s   = bus.data_valid_i && ready_s;
        if (MSB_FIRST) begin
            out_bit_s = shreg_q[WIDTH-1];
            shifted_s = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            out_bit_s = shreg_q[0];
            shifted_s = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    assign bus.ready_o     = ready_s;
    assign bus.x_o         = !reset && (state_q == S_SHIFT) && out_bit_s;
    assign bus.bit_valid_o = !reset && (state_q == S_SHIFT);
    assign bus.word_last_o = !reset && last_bit_s;
    assign bus.busy_o      = !reset && (state_q != S_IDLE);

    // Next-state logic: a last-bit accept reloads in place so words run back to back.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    shreg_d   = bus.data_i;
                    bit_cnt_d = BIT_LOAD;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_d = shifted_s;
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else if (accept_s) begin
                    shreg_d   = bus.data_i;
                    bit_cnt_d = BIT_LOAD;
                end else if (HAS_GAP) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end
endmodule
